// File: rtl/dptr_pipe.sv
// Three-stage R-type datapath: decode/regfile read, ALU, result/write-back.
// Full forwarding from the ALU and result stages means the pipeline never stalls.
module dptr_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32,
    localparam int RA_W  = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    input  logic              ld_en,
    input  logic [RA_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              zf,
    output logic              illegal,
    output logic [4:0]        rd_out
);

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] alu(
        input logic [5:0]               f,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        case (f)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_XOR:   return a ^ b;
            F_NOR:   return ~(a | b);
            F_SLT:   return (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            default: return '0;
        endcase
    endfunction

    // A producer only forwards when it will actually write back.
    function automatic logic fwd_hit(
        input logic       vld,
        input logic       ill,
        input logic [4:0] rd,
        input logic [4:0] src
    );
        return vld && !ill && (rd != 5'd0) && (rd == src);
    endfunction

    logic [DATA_W-1:0] regfile [REG_N];

    logic                     vld_p1, ill_p1;
    logic [5:0]               funct_p1;
    logic [4:0]               rd_p1;
    logic signed [DATA_W-1:0] a_p1, b_p1, alu_p1;

    logic                     vld_p2, ill_p2;
    logic [4:0]               rd_p2;
    logic signed [DATA_W-1:0] res_p2;
    logic                     wb_en;

    // ---- S0: decode, regfile read, operand forwarding ----
    logic [5:0]               op_p0, funct_p0;
    logic [4:0]               rs_p0, rt_p0, rd_p0;
    logic                     rs_ok, rt_ok, rd_ok, ill_p0;
    logic [DATA_W-1:0]        rf_rs, rf_rt, dbg_rd;
    logic signed [DATA_W-1:0] opa_p0, opb_p0;
    logic                     unused_shamt;

    assign op_p0        = instr[31:26];
    assign rs_p0        = instr[25:21];
    assign rt_p0        = instr[20:16];
    assign rd_p0        = instr[15:11];
    assign funct_p0     = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    // Register 0 is never read from storage, and a same-cycle preload bypasses the array.
    always_comb begin
        rs_ok  = 1'b0;
        rt_ok  = 1'b0;
        rd_ok  = 1'b0;
        rf_rs  = '0;
        rf_rt  = '0;
        dbg_rd = '0;
        for (int i = 0; i < REG_N; i++) begin
            if (rs_p0 == 5'(i)) rs_ok = 1'b1;
            if (rt_p0 == 5'(i)) rt_ok = 1'b1;
            if (rd_p0 == 5'(i)) rd_ok = 1'b1;
        end
        for (int i = 1; i < REG_N; i++) begin
            if (rs_p0 == 5'(i))
                rf_rs = (ld_en && ld_addr == RA_W'(i)) ? ld_data : regfile[i];
            if (rt_p0 == 5'(i))
                rf_rt = (ld_en && ld_addr == RA_W'(i)) ? ld_data : regfile[i];
            if (dbg_addr == RA_W'(i))
                dbg_rd = regfile[i];
        end
    end

    assign ill_p0 = (op_p0 != 6'd0) || !funct_ok(funct_p0) || !rs_ok || !rt_ok || !rd_ok;

    always_comb begin
        if (fwd_hit(vld_p1, ill_p1, rd_p1, rs_p0))      opa_p0 = alu_p1;
        else if (fwd_hit(vld_p2, ill_p2, rd_p2, rs_p0)) opa_p0 = res_p2;
        else                                            opa_p0 = rf_rs;
        if (fwd_hit(vld_p1, ill_p1, rd_p1, rt_p0))      opb_p0 = alu_p1;
        else if (fwd_hit(vld_p2, ill_p2, rd_p2, rt_p0)) opb_p0 = res_p2;
        else                                            opb_p0 = rf_rt;
    end

    // ---- S1: operand registers and ALU ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            ill_p1   <= 1'b0;
            funct_p1 <= '0;
            rd_p1    <= '0;
            a_p1     <= '0;
            b_p1     <= '0;
        end else begin
            vld_p1 <= instr_valid;
            if (instr_valid) begin
                ill_p1   <= ill_p0;
                funct_p1 <= funct_p0;
                rd_p1    <= rd_p0;
                a_p1     <= opa_p0;
                b_p1     <= opb_p0;
            end
        end
    end

    assign alu_p1 = ill_p1 ? '0 : alu(funct_p1, a_p1, b_p1);

    // ---- S2: result registers, outputs and write-back ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            ill_p2 <= 1'b0;
            rd_p2  <= '0;
            res_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                ill_p2 <= ill_p1;
                rd_p2  <= rd_p1;
                res_p2 <= alu_p1;
            end
        end
    end

    assign wb_en = vld_p2 && !ill_p2 && (rd_p2 != 5'd0);

    // Write-back takes priority over a preload to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) regfile[i] <= '0;
        end else begin
            for (int i = 1; i < REG_N; i++) begin
                if (wb_en && rd_p2 == 5'(i))
                    regfile[i] <= res_p2;
                else if (ld_en && ld_addr == RA_W'(i))
                    regfile[i] <= ld_data;
            end
        end
    end

    assign out_valid = vld_p2;
    assign result    = res_p2;
    assign zf        = (res_p2 == '0);
    assign illegal   = ill_p2;
    assign rd_out    = rd_p2;
    assign dbg_data  = dbg_rd;

endmodule

// File: doc/dptr_pipe.md
# dptr_pipe

Pipelined, parametrised R-type datapath: register file, ALU and write-back with full forwarding. It accepts one MIPS-format R-type instruction per cycle and produces the result and zero flag two cycles later. The result is written back into the register file one edge after that. It sits between the instruction source (fetch/control) and the rest of the core.

## Interface
Parameters:
- DATA_W, 32, datapath and register width (≥ 8)
- REG_N, 32, number of architectural registers (2..32); index width RA_W = $clog2(REG_N)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instr is valid this cycle; no backpressure
- instr  in  32  {op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]}
- ld_en  in  1  direct register preload strobe
- ld_addr  in  RA_W  preload target
- ld_data  in  DATA_W  preload value
- dbg_addr  in  RA_W  debug read address
- dbg_data  out  DATA_W  combinational regfile[dbg_addr]
- out_valid  out  1  result stage holds a valid instruction
- result  out  DATA_W  ALU result
- zf  out  1  result == 0
- illegal  out  1  instruction was undecodable
- rd_out  out  5  destination field of the result-stage instruction

## Operation
- Stages:
  - S0: decode and read the register file.
  - S1: operand registers and ALU.
  - S2: result registers, which drive the outputs and perform write-back.
- Register 0 reads as 0 and is never written, by preload or by write-back.
- Funct encoding (op must be 000000):
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 100110 xor
  - 100111 nor
  - 101010 slt, signed compare, result 1 or 0 zero-extended
- shamt is ignored.
- add and sub wrap modulo 2^DATA_W. No overflow flag.
- An instruction is illegal when any of these holds:
  - op ≠ 0
  - funct is unlisted
  - rs, rt or rd ≥ REG_N
- An illegal instruction still flows through the pipeline. At S2 it shows out_valid=1, illegal=1, result=0, zf=1, and performs no write-back.
- Operand forwarding for rs and rt, newest first:
  1. The S1 ALU output, when S1 is valid, legal, rd ≠ 0 and rd matches.
  2. The S2 result, under the same conditions.
  3. The register file; a same-cycle ld_en to that address forwards ld_data.
- No stalls are ever required.
- Write-back: when S2 is valid, legal and rd ≠ 0, regfile[rd] ← result at the next edge.
- If ld_en and write-back target the same register in the same cycle, write-back wins. Writes to different registers both occur.
- A bubble (instr_valid=0) propagates as valid=0. The data registers hold their last values.

## Timing
- Instruction presented in cycle t is captured into S1 at edge t+1. It appears on the outputs with out_valid=1 during cycle t+2, and is written to the register file at edge t+3.
- Throughput is one instruction per cycle.
- dbg_data reflects the register file combinationally. A write is visible the cycle after its edge.
- Reset values:
  - all registers = 0
  - out_valid=0, result=0, zf=1, illegal=0, rd_out=0
  - S1 valid = 0
- Reset asserted mid-stream discards every in-flight instruction: none of them writes back.
- The first instruction after reset deasserts is accepted on the first rising edge.

## Test plan
- Basic add:
  - Stimulus: preload r2=123, r3=456, then add r1=r2+r3.
  - Required: cycle t+2 shows result=579, zf=0, rd_out=1; dbg r1=579 after edge t+3.
- Back-to-back forwarding:
  - Stimulus: preload r7=321. Issue add r1=r2+r3 (579), then immediately sub r4=r1−r7, then immediately or r5=r1|r4.
  - Required: the sub gives 258, which exercises the S1 forward. The or gives 579|258=835, which exercises the S2 and S1 forwards.
- Zero flag and slt:
  - Stimulus: sub r5=r2−r2; preload r6=−5 (two's complement); slt r8=r6<r2; slt r9=r2<r6.
  - Required: the sub gives result 0 with zf=1. slt r8 gives 1. slt r9 gives 0 with zf=1.
- Register 0 and illegal instructions:
  - Stimulus: add r0=r2+r3; then op=000010; then funct=000001.
  - Required: r0 stays 0 and no later operand sees 579 through r0. Both illegal instructions show illegal=1, result=0, and make no register change.
- Reset mid-stream:
  - Stimulus: issue three adds on consecutive cycles, then assert rst asynchronously between edges.
  - Required: outputs drop to their reset values immediately, all registers read 0, and there is no out_valid after rst releases until a new instruction arrives.
- Preload/write-back collision:
  - Stimulus: ld_en r1=999 in the same cycle that add r1=579 writes back.
  - Required: r1=579.
